// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: shared AHB3-Lite encodings and a transfer-alignment helper.
package ahb3lite_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HWORD   = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   function automatic logic ahb_illegal(input logic [2:0] size, input logic [1:0] addr_lo);
      return size > HSIZE_WORD || (size == HSIZE_HWORD && addr_lo[0]) ||
             (size == HSIZE_WORD && addr_lo != 2'b00);
   endfunction
endpackage

// File: rtl/ahb3lite_cmd_master.sv
// ahb3lite_cmd_master: single-outstanding AHB3-Lite master behind a command/response handshake.
// Define AHB3LITE_CMD_MASTER_TIMEOUT_EN to add an HREADY-low watchdog of TIMEOUT cycles.
module ahb3lite_cmd_master
   import ahb3lite_pkg::*;
#(
   parameter int TIMEOUT = 256
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic        CMD_WRITE,
   input  logic [31:0] CMD_ADDR,
   input  logic [31:0] CMD_WDATA,
   input  logic [2:0]  CMD_SIZE,
   output logic        RSP_VALID,
   input  logic        RSP_READY,
   output logic [31:0] RSP_RDATA,
   output logic        RSP_ERR,
   output logic [31:0] HADDR,
   output logic [31:0] HWDATA,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic [1:0]  HTRANS,
   output logic        HMASTLOCK,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   if (TIMEOUT < 2) begin : g_timeout_chk
      $error("TIMEOUT must be at least 2");
   end

   state_t      state_q, state_d;
   logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d, rdata_q, rdata_d;
   logic        hwrite_q, hwrite_d, err_q, err_d;
   logic [2:0]  hsize_q, hsize_d;
   logic        expired;

`ifdef AHB3LITE_CMD_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [31:0] TIMEOUT_RDATA = 32'hdeadbeef;
   logic [CW-1:0] cnt_q, cnt_d;
   assign expired = !HREADY && cnt_q == CW'(TIMEOUT - 1);
   // Any state change restarts the count, so each phase gets a full TIMEOUT budget.
   always_comb
      cnt_d = (state_d != state_q) ? '0 :
              (!HREADY && (state_q == ADDR || state_q == DATA)) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) cnt_q <= '0;
      else       cnt_q <= cnt_d;
`else
   assign expired = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      haddr_d  = haddr_q;
      hwdata_d = hwdata_q;
      hwrite_d = hwrite_q;
      hsize_d  = hsize_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         IDLE: if (CMD_VALID) begin
            if (ahb_illegal(CMD_SIZE, CMD_ADDR[1:0])) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               state_d  = ADDR;
               haddr_d  = CMD_ADDR;
               hwdata_d = CMD_WDATA;
               hwrite_d = CMD_WRITE;
               hsize_d  = CMD_SIZE;
            end
         end
         ADDR, DATA: if (expired) begin
            state_d = RESP;
            err_d   = 1'b1;
`ifdef AHB3LITE_CMD_MASTER_TIMEOUT_EN
            rdata_d = TIMEOUT_RDATA;
`else
            rdata_d = '0;
`endif
         end else if (HREADY) begin
            state_d = (state_q == ADDR) ? DATA : RESP;
            if (state_q == DATA) begin
               err_d   = HRESP == HRESP_ERROR;
               rdata_d = (HRESP == HRESP_ERROR || hwrite_q) ? '0 : HRDATA;
            end
         end
         RESP: if (RSP_READY) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         state_q  <= IDLE;
         haddr_q  <= '0;
         hwdata_q <= '0;
         hwrite_q <= 1'b0;
         hsize_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         haddr_q  <= haddr_d;
         hwdata_q <= hwdata_d;
         hwrite_q <= hwrite_d;
         hsize_q  <= hsize_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end

   assign CMD_READY = state_q == IDLE && !RESET;
   assign RSP_VALID = state_q == RESP;
   assign RSP_RDATA = rdata_q;
   assign RSP_ERR   = err_q;
   assign HADDR     = haddr_q;
   assign HWDATA    = hwdata_q;
   assign HWRITE    = hwrite_q;
   assign HSIZE     = hsize_q;
   assign HTRANS    = state_q == ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HBURST    = HBURST_SINGLE;
   assign HPROT     = 4'b0011;
   assign HMASTLOCK = 1'b0;
endmodule
